// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: measures the period and high time of a slow external
// square wave in clk_interno cycles, and flags when the wave stops.
// Results are registered and announced by a one-cycle valido strobe.
module medidor_frecuencia #(
    parameter int unsigned ANCHO   = 25,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic             clk_interno,
    input  logic             rst_n,
    input  logic             senal_entrada,
    output logic [ANCHO-1:0] periodo,
    output logic [ANCHO-1:0] alto,
    output logic             valido,
    output logic             sin_senal
);

    typedef enum logic {
        ESPERA,
        MIDE
    } estado_t;

    localparam logic [ANCHO-1:0] LIMITE = ANCHO'(TIMEOUT);
    localparam logic [ANCHO-1:0] UNO    = ANCHO'(1);

    estado_t          estado;
    estado_t          estado_sig;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             sube;
    logic             baja;

    logic [ANCHO-1:0] cnt;
    logic [ANCHO-1:0] cnt_alto;
    logic [ANCHO-1:0] cnt_mas_uno;
    logic             llega_limite;

    logic             cargar_resultado;
    logic             marcar_sin_senal;
    logic             capturar_alto;

    // Two-flop synchronizer plus a third flop for edge detection.
    always_ff @(posedge clk_interno or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= senal_entrada;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sube         = s2 & ~s3;
    assign baja         = ~s2 & s3;
    assign cnt_mas_uno  = cnt + UNO;
    assign llega_limite = (cnt_mas_uno == LIMITE);

    // State register.
    always_ff @(posedge clk_interno or negedge rst_n) begin
        if (!rst_n) begin
            estado <= ESPERA;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next state and control strobes; a rising edge takes priority over the timeout.
    always_comb begin
        estado_sig       = estado;
        cargar_resultado = 1'b0;
        marcar_sin_senal = 1'b0;
        capturar_alto    = 1'b0;
        case (estado)
            ESPERA: begin
                if (sube) begin
                    estado_sig = MIDE;
                end else if (llega_limite) begin
                    marcar_sin_senal = 1'b1;
                end
            end
            MIDE: begin
                capturar_alto = baja;
                if (sube) begin
                    cargar_resultado = 1'b1;
                end else if (llega_limite) begin
                    marcar_sin_senal = 1'b1;
                    estado_sig       = ESPERA;
                end
            end
            default: begin
                estado_sig = ESPERA;
            end
        endcase
    end

    // Period counter: restarts on every rising edge, saturates at the timeout value.
    always_ff @(posedge clk_interno or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sube) begin
            cnt <= '0;
        end else if (cnt < LIMITE) begin
            cnt <= cnt_mas_uno;
        end
    end

    // High-time capture: cleared on each rising edge so a period without a falling edge reports 0.
    always_ff @(posedge clk_interno or negedge rst_n) begin
        if (!rst_n) begin
            cnt_alto <= '0;
        end else if (sube) begin
            cnt_alto <= '0;
        end else if (capturar_alto) begin
            cnt_alto <= cnt_mas_uno;
        end
    end

    // Registered results, valid strobe and no-signal flag.
    always_ff @(posedge clk_interno or negedge rst_n) begin
        if (!rst_n) begin
            periodo   <= '0;
            alto      <= '0;
            valido    <= 1'b0;
            sin_senal <= 1'b0;
        end else begin
            valido <= cargar_resultado;
            if (cargar_resultado) begin
                periodo   <= cnt_mas_uno;
                alto      <= cnt_alto;
                sin_senal <= 1'b0;
            end else if (marcar_sin_senal) begin
                sin_senal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_medidor_frecuencia.sv
// tb_medidor_frecuencia: randomized square waves, timeouts and resets checked
// cycle by cycle against a reference model based on edge timestamps.
module tb_medidor_frecuencia;

    localparam int AN = 25;
    localparam int TO = 1000;

    logic          clk_interno;
    logic          rst_n;
    logic          senal_entrada;
    logic [AN-1:0] periodo;
    logic [AN-1:0] alto;
    logic          valido;
    logic          sin_senal;

    int n_chequeos = 0;
    int n_errores  = 0;

    medidor_frecuencia #(
        .ANCHO  (AN),
        .TIMEOUT(TO)
    ) dut (
        .clk_interno  (clk_interno),
        .rst_n        (rst_n),
        .senal_entrada(senal_entrada),
        .periodo      (periodo),
        .alto         (alto),
        .valido       (valido),
        .sin_senal    (sin_senal)
    );

    initial clk_interno = 1'b0;
    always #5 clk_interno = ~clk_interno;

    task automatic chequear(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_chequeos++;
        if (obs !== esp) begin
            n_errores++;
            $display("FAIL %s obs=%h esp=%h at %0t", tag, obs, esp, $time);
        end
    endtask

    // Reference model: timestamps of rising/falling input edges, in cycles.
    longint ciclo     = 0;
    longint ult_ref   = 0;
    longint t_baja    = 0;
    bit     armado    = 0;
    bit     hubo_baja = 0;
    bit     x_prev    = 0;
    bit     pendiente = 1;
    bit     m_val     = 0;
    bit     m_sin     = 0;
    int     m_per     = 0;
    int     m_alt     = 0;
    logic [63:0] dl0  = '0;
    logic [63:0] dl1  = '0;
    logic [63:0] obs_v;
    logic        x_now;

    task automatic paso_modelo(input bit x);
        bit sube_m;
        bit baja_m;
        m_val = 0;
        // After reset the cycle count starts as if an edge had just been seen.
        if (pendiente) begin
            ult_ref   = ciclo - 3;
            pendiente = 0;
        end
        sube_m = x & ~x_prev;
        baja_m = ~x & x_prev;
        if (sube_m) begin
            if (armado) begin
                m_val = 1;
                m_per = int'(ciclo - ult_ref);
                m_alt = hubo_baja ? int'(t_baja - ult_ref) : 0;
                m_sin = 0;
            end
            armado    = 1;
            ult_ref   = ciclo;
            hubo_baja = 0;
        end else begin
            if (baja_m && armado) begin
                hubo_baja = 1;
                t_baja    = ciclo;
            end
            if (ciclo - ult_ref == longint'(TO)) begin
                m_sin  = 1;
                armado = 0;
            end
        end
        x_prev = x;
    endtask

    // Outputs seen after a clock edge reflect the input two edges earlier.
    always @(posedge clk_interno) begin
        x_now = senal_entrada;
        ciclo++;
        #1;
        obs_v = {12'd0, valido, sin_senal, periodo, alto};
        if (!rst_n) begin
            chequear("en_reset", obs_v, 64'd0);
            dl0 = '0; dl1 = '0;
            armado = 0; hubo_baja = 0; x_prev = 0; pendiente = 1;
            m_val = 0; m_sin = 0; m_per = 0; m_alt = 0;
        end else begin
            chequear("salida", obs_v, dl1);
            dl1 = dl0;
            paso_modelo(x_now);
            dl0 = {12'd0, m_val, m_sin, m_per[AN-1:0], m_alt[AN-1:0]};
        end
    end

    task automatic tramo(input int h, input int l);
        repeat (h) begin @(negedge clk_interno); senal_entrada = 1'b1; end
        repeat (l) begin @(negedge clk_interno); senal_entrada = 1'b0; end
    endtask

    task automatic pulso_reset(input bit nivel);
        @(negedge clk_interno);
        senal_entrada = nivel;
        rst_n = 1'b0;
        #1;
        chequear("reset_inmediato", {12'd0, valido, sin_senal, periodo, alto}, 64'd0);
        repeat (3) @(negedge clk_interno);
        rst_n = 1'b1;
    endtask

    initial begin
        int h;
        int p;
        rst_n = 1'b0;
        senal_entrada = 1'b0;
        repeat (3) @(negedge clk_interno);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_interno);

        for (int i = 0; i < 5; i++) tramo(3, 7);
        for (int i = 0; i < 10; i++) tramo(1, 1);
        for (int i = 0; i < 40; i++) tramo(int'($urandom_range(1, 30)), int'($urandom_range(1, 30)));

        for (int i = 0; i < 3; i++) tramo(50, 50);
        tramo(50, 1500);
        for (int i = 0; i < 3; i++) tramo(50, 50);

        tramo(1, 999);
        tramo(1, 999);
        tramo(1, 1000);
        tramo(1, 999);
        tramo(1, 999);

        for (int i = 0; i < 16; i++) begin
            p = int'($urandom_range(TO - 2, TO + 2));
            h = int'($urandom_range(1, 500));
            tramo(h, p - h);
        end

        for (int i = 0; i < 4; i++) tramo(3, 7);
        tramo(3, 2);
        pulso_reset(1'b0);
        for (int i = 0; i < 4; i++) tramo(3, 7);

        for (int i = 0; i < 3; i++) tramo(4, 6);
        tramo(2, 0);
        pulso_reset(1'b1);
        tramo(5, 5);
        for (int i = 0; i < 3; i++) tramo(4, 6);

        for (int i = 0; i < 30; i++) tramo(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));

        senal_entrada = 1'b0;
        repeat (1200) @(negedge clk_interno);
        $display("CHECKS %0d ERRORS %0d", n_chequeos, n_errores);
        $finish;
    end

endmodule

// File: doc/medidor_frecuencia.md
Name: medidor_frecuencia

Overview:
- Measures a slow, externally generated square wave in `clk_interno` cycles: period and high time, plus a no-signal flag.
- It is the receiving end of the frequency-divider output. It is used to check divided clocks, and any off-chip pulse train, against the board clock.
- The result feeds the display/LED logic as a registered result with a one-cycle valid strobe.

Parameters:
- ANCHO, 25, width of the cycle counter and of the result outputs.
- TIMEOUT, 1_000_000, number of cycles without a rising edge before the input is declared dead. Must be less than 2^ANCHO.

Ports:
- clk_interno  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- senal_entrada  input  1  measured signal; asynchronous to clk_interno.
- periodo  output  ANCHO  last measured period in clk_interno cycles.
- alto  output  ANCHO  high time of that same period, in cycles.
- valido  output  1  one-cycle pulse when periodo/alto are updated.
- sin_senal  output  1  level; 1 = no rising edge seen within TIMEOUT cycles.

Behaviour:
- Reset, asynchronous on rst_n=0: periodo=0, alto=0, valido=0, sin_senal=0; synchronizer flops=0, counters=0, state=ESPERA.
- Input path: 2-flop synchronizer, then a third flop for edge detection.
  - sube = s2 & ~s3; baja = ~s2 & s3.
  - Input-to-edge-pulse latency is 3 cycles, and it is constant, so periods are unaffected.
- cnt (ANCHO bits):
  - Cleared to 0 in the cycle sube=1.
  - Otherwise increments by 1 and saturates at TIMEOUT.
- cnt_alto: in the cycle baja=1 while in MIDE, cnt_alto <= cnt+1. A baja in ESPERA is ignored.
- FSM ESPERA, waiting for the first rising edge:
  - On sube: go to MIDE, cnt<=0, cnt_alto<=0. No valido.
  - If cnt+1 == TIMEOUT with no sube: sin_senal<=1, stay in ESPERA.
- FSM MIDE:
  - On sube: periodo<=cnt+1, alto<=cnt_alto, valido<=1 for exactly one cycle, sin_senal<=0, cnt<=0, stay in MIDE.
    - For a period of P cycles, periodo=P.
  - If cnt+1 == TIMEOUT with no sube: sin_senal<=1, go to ESPERA. periodo and alto hold their last values.
- The first rising edge after reset or after a timeout never produces valido. Two consecutive edges are needed.
- Simultaneous sube and timeout condition in the same cycle: sube wins. The measurement completes and sin_senal is not set.
- If no falling edge occurred during the period (input stuck high then rising again is impossible), alto reports 0.
- Minimum measurable period is 2 cycles (high 1, low 1). Shorter pulses are lost in the synchronizer.
- sin_senal clears only on a valido, or on reset.
- Reset asserted mid-measurement:
  - Outputs clear immediately.
  - After release, the block restarts in ESPERA, and the edge-detect flops restart from 0.
  - If the input is high at release, one sube occurs after 3 cycles and counts as the first edge.
- Outputs are registered; no combinational path from senal_entrada to any output.

Test Plan:
- Square wave, 250_000 cycles high / 250_000 low, from reset -> first valido roughly 500_003 cycles after the first rising input edge; periodo=500_000, alto=250_000; repeats every 500_000 cycles; sin_senal=0.
- Period 10, high 3 (30% duty), 5 periods -> 4 valido pulses, each periodo=10, alto=3; valido never high for 2 consecutive cycles.
- Period 2 (toggle each cycle) -> periodo=2, alto=1 on every valido.
- Square wave of period 100 then input held low, with TIMEOUT=1000 -> sin_senal rises 1000 cycles after the last sube; periodo stays 100; restart toggling -> first edge gives no valido, second gives periodo=100 and sin_senal=0.
- Boundary with TIMEOUT=1000: edges spaced exactly 1000 cycles -> valido with periodo=1000, sin_senal stays 0. Spacing 1001 -> sin_senal=1 and no valido for that interval.
- rst_n pulsed low for 3 cycles mid-period during a period-10 wave -> all outputs 0 immediately; the next valido comes only after two post-reset rising edges, with periodo=10.
